shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Initiator side of the gated-pulse shift interface.
- Accepts a total shift-amount command over a valid/ready handshake and splits it into chunks of at most 2^N_WIDTH-1 pulses.
- For each chunk it drives the pulse generator's init/N inputs, waits for its done flag, and returns one response per command.
- Per-chunk watchdog and abort input guarantee the datapath never hangs.

Parameters:
- N_WIDTH, 5: width of N_o; max chunk MAX_CHUNK = 2^N_WIDTH-1.
- TOT_WIDTH, 10: width of requested total amount and reported count.
- TIMEOUT_CYCLES, 64: max RUN cycles per chunk before error; must be > MAX_CHUNK+1.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accept; high only in IDLE.
- req_amount_i  in  TOT_WIDTH  total pulses requested.
- abort_i  in  1  cancel current command, sampled in SETUP/RUN.
- init_o  out  1  pulse-generator enable; low also clears its counter.
- N_o  out  N_WIDTH  pulses for current chunk.
- shift_done_i  in  1  pulse generator's count==N flag (combinational on its side).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_error_o  out  1  1 = timeout or abort.
- rsp_count_o  out  TOT_WIDTH  pulses completed (sum of finished chunks).
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: state=IDLE, init_o=0, N_o=0, req_ready_o=1, rsp_valid_o=0, rsp_error_o=0, rsp_count_o=0, busy_o=0. All internal registers are cleared.
- IDLE, handshake with req_amount_i==0: go to RESP with count=0, error=0. No init_o assertion.
- IDLE, handshake with req_amount_i>0: latch remaining=amount, done_cnt=0, go to SETUP.
- SETUP (exactly 1 cycle):
  - init_o=0 (guarantees the generator counter is cleared).
  - N_o = min(remaining, MAX_CHUNK), registered and held stable through the following RUN.
  - Clear the watchdog.
  - Next state RUN.
- RUN:
  - init_o=1. shift_done_i is sampled every cycle, including the first RUN cycle.
  - Watchdog increments once per RUN cycle.
  - On shift_done_i=1: done_cnt += N_o, remaining -= N_o. If the new remaining > 0, go to SETUP; otherwise go to RESP with error=0.
  - Else, on watchdog reaching TIMEOUT_CYCLES: go to RESP with error=1 and done_cnt unchanged.
- Abort, in SETUP or RUN: abort_i=1 goes to RESP with error=1, done_cnt excludes the partial chunk, and init_o drops the next cycle.
- Priority within one cycle: shift_done_i > abort_i > timeout. A done arriving with abort counts the chunk and still reports error=1.
- RESP:
  - init_o=0; rsp_valid_o=1 with rsp_error_o and rsp_count_o stable.
  - On rsp_ready_i=1, go to IDLE. Back-pressure holds all response outputs stable.
- init_o is registered (no glitches) and is low in every state except RUN.
- Latency for amount A<=MAX_CHUNK with a compliant generator:
  - handshake at cycle 0, SETUP at cycle 1, init_o high from cycle 2;
  - done at cycle 2+A, rsp_valid_o at cycle 3+A.
- Multi-chunk commands add 1 SETUP cycle per chunk boundary.
- Arithmetic:
  - remaining and done_cnt are TOT_WIDTH unsigned and never overflow (done_cnt <= amount).
  - Chunk compare is done in TOT_WIDTH and zero-extended N_o.
- An async reset mid-RUN returns to the reset values immediately; init_o falls asynchronously.
- shift_done_i is ignored outside RUN; while idle it is high when N_o==0, which is harmless.

Decomposition:
- Package shift_seq_pkg: state enum {IDLE, SETUP, RUN, RESP} as a 2-bit logic typedef.
- Function min_chunk(remaining) with MAX_CHUNK derived from N_WIDTH.
- Sub-module shift_watchdog: clear/enable counter with a terminal flag at TIMEOUT_CYCLES, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Bench drives the real pulse generator as DUT load.
- Amount=5, rsp_ready=1: N_o=5, init_o high cycles 2..7 → rsp_valid cycle 8, count=5, error=0; exactly 5 gated pulses observed.
- Amount=40: chunks N_o=31 then 9, each preceded by a 1-cycle init_o=0 SETUP → count=40, error=0, 40 pulses total.
- Amount=0 → response cycle 1, count=0, error=0, init_o never high.
- Done stuck low (generator replaced by model), amount=10 → after 64 RUN cycles: rsp error=1, count=0, init_o low.
- Amount=40, abort_i pulsed during second chunk RUN → error=1, count=31.
- Abort in the same cycle as done of the first chunk → count=31, error=1.
- rsp_ready=0 for 5 cycles → rsp outputs stable and req_ready_o=0.
- Mid-RUN reset → all outputs at reset values, init_o low asynchronously.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the gated-pulse shift sequencer.
// Contents: FSM state encoding and the chunk-size helper.
// Imported by shift_sequencer and shift_watchdog.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_RUN   = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Largest chunk the generator can count is 2^n_width-1; return the
   // smaller of that and what is still outstanding.
   function automatic int unsigned min_chunk(input int unsigned remaining,
                                             input int unsigned n_width);
      int unsigned max_chunk;
      max_chunk = (32'd1 << n_width) - 32'd1;
      return (remaining < max_chunk) ? remaining : max_chunk;
   endfunction

endpackage

// File: rtl/shift_watchdog.sv
// Per-chunk watchdog: counts enabled cycles, flags the TIMEOUT_CYCLES-th one.
// Latency: expire_o is combinational in the cycle the count would reach TIMEOUT_CYCLES.
// Backpressure: none; clr_i wins over en_i, counter saturates at the terminal value.
// Ports: clk_i/rstn_i clock and async active-low reset; clr_i clear; en_i count enable;
//        expire_o high during the enabled cycle that completes TIMEOUT_CYCLES counts.
module shift_watchdog
   import shift_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TERM    = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST_EN = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != TERM)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires in the cycle whose increment takes the count to TIMEOUT_CYCLES,
   // so the owner spends exactly TIMEOUT_CYCLES enabled cycles before giving up.
   assign expire_o = en_i && (cnt_q == LAST_EN);

endmodule

// File: rtl/shift_sequencer.sv
// Splits a total shift command into generator chunks and returns one response per command.
// Latency: A<=MAX_CHUNK -> SETUP at +1, init_o from +2, response at +3+A; +1 per extra chunk.
// Backpressure: req_ready_o only in IDLE; response held stable while rsp_ready_i is low.
// Ports: req_* command handshake; abort_i cancel; init_o/N_o/shift_done_i pulse-generator
//        control; rsp_* response handshake with error flag and completed count; busy_o.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int unsigned N_WIDTH        = 5,
   parameter int unsigned TOT_WIDTH      = 10,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [TOT_WIDTH-1:0] req_amount_i,
   input  logic                 abort_i,
   output logic                 init_o,
   output logic [N_WIDTH-1:0]   N_o,
   input  logic                 shift_done_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic                 rsp_error_o,
   output logic [TOT_WIDTH-1:0] rsp_count_o,
   output logic                 busy_o
);

   state_e                state_q, state_d;
   logic [TOT_WIDTH-1:0]  remaining_q, remaining_d;
   logic [TOT_WIDTH-1:0]  done_cnt_q, done_cnt_d;
   logic [N_WIDTH-1:0]    n_q, n_d;
   logic                  init_q, init_d;
   logic                  err_q, err_d;

   logic                  wd_clr, wd_en, wd_expire;
   logic [TOT_WIDTH-1:0]  chunk_ext;
   logic [TOT_WIDTH-1:0]  rem_after;

   // Chunk arithmetic stays in TOT_WIDTH; N_o is zero-extended.
   assign chunk_ext = TOT_WIDTH'(n_q);
   assign rem_after = remaining_q - chunk_ext;

   shift_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      done_cnt_d  = done_cnt_q;
      n_d         = n_q;
      err_d       = err_q;
      wd_clr      = 1'b0;
      wd_en       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               done_cnt_d = '0;
               err_d      = 1'b0;
               if (req_amount_i == '0) begin
                  state_d = ST_RESP;
               end else begin
                  remaining_d = req_amount_i;
                  // N_o is loaded on entry to SETUP so it is already stable
                  // while init_o is low and the generator counter clears.
                  n_d         = N_WIDTH'(min_chunk(32'(req_amount_i), N_WIDTH));
                  state_d     = ST_SETUP;
               end
            end
         end

         ST_SETUP: begin
            wd_clr = 1'b1;
            if (abort_i) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            wd_en = 1'b1;
            // A finished chunk is always credited, even if abort or the
            // watchdog fire in the same cycle.
            if (shift_done_i) begin
               done_cnt_d  = done_cnt_q + chunk_ext;
               remaining_d = rem_after;
               if (abort_i) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (rem_after != '0) begin
                  n_d     = N_WIDTH'(min_chunk(32'(rem_after), N_WIDTH));
                  state_d = ST_SETUP;
               end else begin
                  state_d = ST_RESP;
               end
            end else if (abort_i || wd_expire) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered from the next state so init_o is glitch-free and high only in RUN.
   assign init_d = (state_d == ST_RUN);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         done_cnt_q  <= '0;
         n_q         <= '0;
         init_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         done_cnt_q  <= done_cnt_d;
         n_q         <= n_d;
         init_q      <= init_d;
         err_q       <= err_d;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_error_o = err_q;
   assign rsp_count_o = done_cnt_q;
   assign init_o      = init_q;
   assign N_o         = n_q;

endmodule
